// File: rtl/axi_arb_pkg.sv
// Shared types and AXI encodings for the write-side arbiter and its picker.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // ptr itself is searched last, so the previous owner has lowest priority
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write port (AW/W/B) among NREQ requesters.
// Optional AXI_WR_ARB_BEAT_CHECK_EN: generate m_wlast from beat count and flag wlast errors.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 64
) (
  input  logic                 axi_aclk,
  input  logic                 rst,
  input  logic [NREQ*AW-1:0]   req_awaddr,
  input  logic [NREQ*8-1:0]    req_awlen,
  input  logic [NREQ*3-1:0]    req_awsize,
  input  logic [NREQ*2-1:0]    req_awburst,
  input  logic [NREQ-1:0]      req_awvalid,
  output logic [NREQ-1:0]      req_awready,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*DW/8-1:0] req_wstrb,
  input  logic [NREQ-1:0]      req_wlast,
  input  logic [NREQ-1:0]      req_wvalid,
  output logic [NREQ-1:0]      req_wready,
  output logic [1:0]           req_bresp,
  output logic [NREQ-1:0]      req_bvalid,
  input  logic [NREQ-1:0]      req_bready,
  output logic [AW-1:0]        m_awaddr,
  output logic [7:0]           m_awlen,
  output logic [2:0]           m_awsize,
  output logic [1:0]           m_awburst,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [DW-1:0]        m_wdata,
  output logic [DW/8-1:0]      m_wstrb,
  output logic                 m_wlast,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic [NREQ-1:0]      grant
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
  ,
  output logic                 err_wlast
`endif
);

  localparam int SW = DW / 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_reg;
  logic [NREQ-1:0] grant_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [7:0]      beat_cnt_reg;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   grant_idx;

  logic [AW-1:0]   awaddr_arr  [NREQ];
  logic [7:0]      awlen_arr   [NREQ];
  logic [2:0]      awsize_arr  [NREQ];
  logic [1:0]      awburst_arr [NREQ];
  logic [DW-1:0]   wdata_arr   [NREQ];
  logic [SW-1:0]   wstrb_arr   [NREQ];

  logic [AW-1:0]   sel_awaddr;
  logic [7:0]      sel_awlen;
  logic [2:0]      sel_awsize;
  logic [1:0]      sel_awburst;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;
  logic            sel_awvalid;
  logic            sel_wvalid;
  logic            sel_wlast;
  logic            sel_bready;

  logic in_addr, in_data, in_resp;
  logic aw_hs, w_hs, b_hs;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign awaddr_arr[gi]  = req_awaddr[gi*AW +: AW];
      assign awlen_arr[gi]   = req_awlen[gi*8 +: 8];
      assign awsize_arr[gi]  = req_awsize[gi*3 +: 3];
      assign awburst_arr[gi] = req_awburst[gi*2 +: 2];
      assign wdata_arr[gi]   = req_wdata[gi*DW +: DW];
      assign wstrb_arr[gi]   = req_wstrb[gi*SW +: SW];
    end
  endgenerate

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (req_awvalid),
    .ptr (rr_ptr_reg),
    .gnt (pick)
  );

  // grant_reg is one-hot or zero, so a priority mux is equivalent to an AND-OR mux
  always_comb begin
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awsize  = '0;
    sel_awburst = '0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_reg[i]) begin
        sel_awaddr  = awaddr_arr[i];
        sel_awlen   = awlen_arr[i];
        sel_awsize  = awsize_arr[i];
        sel_awburst = awburst_arr[i];
        sel_wdata   = wdata_arr[i];
        sel_wstrb   = wstrb_arr[i];
        grant_idx   = PW'(i);
      end
    end
  end

  assign sel_awvalid = |(req_awvalid & grant_reg);
  assign sel_wvalid  = |(req_wvalid & grant_reg);
  assign sel_wlast   = |(req_wlast & grant_reg);
  assign sel_bready  = |(req_bready & grant_reg);

  assign in_addr = (state_reg == ADDR);
  assign in_data = (state_reg == DATA);
  assign in_resp = (state_reg == RESP);

  assign m_awvalid = in_addr & sel_awvalid;
  assign m_awaddr  = in_addr ? sel_awaddr  : '0;
  assign m_awlen   = in_addr ? sel_awlen   : '0;
  assign m_awsize  = in_addr ? sel_awsize  : '0;
  assign m_awburst = in_addr ? sel_awburst : '0;

  assign m_wvalid = in_data & sel_wvalid;
  assign m_wdata  = in_data ? sel_wdata : '0;
  assign m_wstrb  = in_data ? sel_wstrb : '0;

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
  assign m_wlast   = in_data & (beat_cnt_reg == 8'd0);
  assign err_wlast = w_hs & (sel_wlast != (beat_cnt_reg == 8'd0));
`else
  assign m_wlast   = in_data & sel_wlast;
`endif

  assign m_bready  = in_resp & sel_bready;
  assign req_bresp = m_bresp;

  assign req_awready = in_addr ? (grant_reg & {NREQ{m_awready}}) : '0;
  assign req_wready  = in_data ? (grant_reg & {NREQ{m_wready}})  : '0;
  assign req_bvalid  = in_resp ? (grant_reg & {NREQ{m_bvalid}})  : '0;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  assign grant = grant_reg;

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= PW'(NREQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_awvalid) begin
            grant_reg <= pick;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            beat_cnt_reg <= sel_awlen;
            state_reg    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (beat_cnt_reg != 8'd0) begin
              beat_cnt_reg <= beat_cnt_reg - 8'd1;
            end
            if (m_wlast) begin
              state_reg <= RESP;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            rr_ptr_reg <= grant_idx;
            grant_reg  <= '0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          grant_reg <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
